// File: rtl/pp_sb_pkg.sv
// Shared types and helpers for the rdy/ack stream scoreboard.
// Error-bit indices give the layout of the sticky flag and event vectors.
package pp_sb_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } sb_state_t;

    localparam int ERR_HOLD_IN  = 0;
    localparam int ERR_HOLD_OUT = 1;
    localparam int ERR_DATA     = 2;
    localparam int ERR_OVF      = 3;
    localparam int ERR_UNF      = 4;
    localparam int ERR_TIMEOUT  = 5;
    localparam int N_ERR        = 6;

    // Increment v, holding at 2^w-1 (w up to 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pp_hold_check.sv
// Hold-rule tracker for one side of a rdy/ack link: once rdy is up without ack,
// the next cycle must present the same rdy and data.
module pp_hold_check
    import pp_sb_pkg::*;
#(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rdy,
    input  logic          ack,
    input  logic [BW-1:0] dat,
    output logic          viol
);

    logic          stall_q;
    logic [BW-1:0] dat_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
            dat_q   <= '0;
        end else begin
            stall_q <= rdy & ~ack;
            dat_q   <= dat;
        end
    end

    assign viol = stall_q & (~rdy | (dat != dat_q));

endmodule

// File: rtl/pp_stream_scoreboard.sv
// In-order scoreboard across a pass-through rdy/ack pipeline: expected-data FIFO,
// hold checks, sticky error flags and saturating counters. Stall watchdog under PP_SB_TIMEOUT_EN.
//
// state | meaning
// RUN   | tracking traffic, flags and counters update
// FAULT | error seen with STOP_ERR=1; everything frozen until reset
module pp_stream_scoreboard #(
    parameter int BW       = 8,
    parameter int AW       = 4,
    parameter int CW       = 16,
    parameter int STOP_ERR = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_rdy,
    input  logic          in_ack,
    input  logic [BW-1:0] in_dat,
    input  logic          out_rdy,
    input  logic          out_ack,
    input  logic [BW-1:0] out_dat,
    output logic          err_hold_in,
    output logic          err_hold_out,
    output logic          err_data,
    output logic          err_ovf,
    output logic          err_unf,
    output logic          err_timeout,
    output logic          fault,
    output logic [CW-1:0] n_in,
    output logic [CW-1:0] n_out,
    output logic [CW-1:0] n_err,
    output logic [AW:0]   level
);
    import pp_sb_pkg::*;

    localparam int DEPTH = 1 << AW;

    logic [BW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    sb_state_t        state;
    logic [N_ERR-1:0] err_q, evt;
    logic             push, pop, empty, full, do_push, do_pop;
    logic             hold_in_viol, hold_out_viol, tmo_evt;

    pp_hold_check #(.BW(BW)) u_hold_in (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (in_rdy),
        .ack   (in_ack),
        .dat   (in_dat),
        .viol  (hold_in_viol)
    );

    pp_hold_check #(.BW(BW)) u_hold_out (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (out_rdy),
        .ack   (out_ack),
        .dat   (out_dat),
        .viol  (hold_out_viol)
    );

    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    always_comb begin
        push    = in_rdy & in_ack;
        pop     = out_rdy & out_ack;
        empty   = (level == '0);
        full    = (level == DEPTH[AW:0]);
        do_pop  = pop & ~empty;
        do_push = push & ~(full & ~do_pop);
        evt               = '0;
        evt[ERR_HOLD_IN]  = hold_in_viol;
        evt[ERR_HOLD_OUT] = hold_out_viol;
        evt[ERR_DATA]     = do_pop & (out_dat != mem[rp]);
        evt[ERR_OVF]      = push & full & ~do_pop;
        evt[ERR_UNF]      = pop & empty;
        evt[ERR_TIMEOUT]  = tmo_evt;
    end

`ifdef PP_SB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] stall_cnt;

    // Down-counter from TIMEOUT; the event fires on the step that reaches zero.
    always_comb tmo_evt = ~pop & ~empty & (stall_cnt == TW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= TW'(TIMEOUT);
        end else if (state == RUN) begin
            if (pop || empty)
                stall_cnt <= TW'(TIMEOUT);
            else if (stall_cnt != '0)
                stall_cnt <= stall_cnt - TW'(1);
        end
    end
`else
    assign tmo_evt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            err_q <= '0;
            n_in  <= '0;
            n_out <= '0;
            n_err <= '0;
            level <= '0;
            wp    <= '0;
            rp    <= '0;
        end else if (state == RUN) begin
            err_q <= err_q | evt;
            if (push)
                n_in <= CW'(sat_inc(32'(n_in), CW));
            if (pop)
                n_out <= CW'(sat_inc(32'(n_out), CW));
            if (|evt)
                n_err <= CW'(sat_inc(32'(n_err), CW));
            if (do_push)
                wp <= wp + AW'(1);
            if (do_pop)
                rp <= rp + AW'(1);
            if (do_push && !do_pop)
                level <= level + (AW + 1)'(1);
            else if (!do_push && do_pop)
                level <= level - (AW + 1)'(1);
            if ((STOP_ERR != 0) && (|evt))
                state <= FAULT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && (state == RUN) && do_push)
            mem[wp] <= in_dat;
    end

    assign err_hold_in  = err_q[ERR_HOLD_IN];
    assign err_hold_out = err_q[ERR_HOLD_OUT];
    assign err_data     = err_q[ERR_DATA];
    assign err_ovf      = err_q[ERR_OVF];
    assign err_unf      = err_q[ERR_UNF];
    assign err_timeout  = err_q[ERR_TIMEOUT];
    assign fault        = (state == FAULT);

endmodule
